// File: rtl/mux_stream_arb_pkg.sv
// Shared constants for the stream multiplexer: arbitration mode encodings
// and the select-index width helper.
package mux_stream_arb_pkg;

    localparam int MUX_MODE_SEL  = 0;
    localparam int MUX_MODE_RR   = 1;
    localparam int MUX_MODE_PRIO = 2;

    // Channel index width; a 1-bit index is kept even for the smallest N.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_stream_arb_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr and wraps N-1 -> 0.
// With ptr tied to zero it behaves as a fixed lowest-index-wins arbiter.
module rr_arbiter
    import mux_stream_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int cand;

    // First requesting channel at or after ptr wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// N-channel registered stream multiplexer with valid/ready handshake and a
// one-deep output stage; grant by external select, round-robin or priority.
module mux_stream_arb
    import mux_stream_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MUX_MODE_SEL,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    input  logic               out_ready
);

    logic [N-1:0]     grant_oh_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic             grant_valid_s;
    logic             space_s;
    logic             xfer_s;
    logic [WIDTH-1:0] grant_data_s;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [SEL_W-1:0] out_chan_d,  out_chan_q;

    generate
        if (MODE == MUX_MODE_SEL) begin : g_sel
            logic [N-1:0] sel_oh_s;

            // An out-of-range select decodes to no grant at all.
            always_comb begin
                sel_oh_s = '0;
                for (int i = 0; i < N; i++) begin
                    if (sel == SEL_W'(i)) begin
                        sel_oh_s[i] = 1'b1;
                    end else begin
                        sel_oh_s[i] = 1'b0;
                    end
                end
            end

            assign grant_oh_s    = sel_oh_s & in_valid;
            assign grant_idx_s   = sel;
            assign grant_valid_s = |grant_oh_s;
        end else begin : g_arb
            logic [SEL_W-1:0] ptr_s;

            if (MODE == MUX_MODE_RR) begin : g_rr
                logic [SEL_W-1:0] rr_ptr_d, rr_ptr_q;

                // Pointer moves past the winner only when a word is accepted.
                always_comb begin
                    rr_ptr_d = rr_ptr_q;
                    if (xfer_s) begin
                        rr_ptr_d = (grant_idx_s == SEL_W'(N - 1)) ? '0 : grant_idx_s + 1'b1;
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end

                // Round-robin pointer register.
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        rr_ptr_q <= '0;
                    end else begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                end

                assign ptr_s = rr_ptr_q;
            end else begin : g_prio
                assign ptr_s = '0;
            end

            rr_arbiter #(.N(N), .PW(SEL_W)) u_arb (
                .req (in_valid),
                .ptr (ptr_s),
                .gnt (grant_oh_s),
                .idx (grant_idx_s),
                .any (grant_valid_s)
            );
        end
    endgenerate

    assign space_s  = !out_valid_q || out_ready;
    assign xfer_s   = reset && space_s && grant_valid_s;
    assign in_ready = xfer_s ? grant_oh_s : '0;

    // Data path follows the one-hot grant so no out-of-range index is formed.
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh_s[i]) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    // Load on accept, drain on consume; data and channel persist after drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_chan_d  = grant_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Bench for mux_stream_arb: one instance per MODE on shared stimulus, a cycle
// model with a scoreboard, a vector table and hand-written corner sequences.
module tb_mux_stream_arb;
    import mux_stream_arb_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   rdy [3];
    logic         ov  [3];
    logic [31:0]  od  [3];
    logic [1:0]   oc  [3];

    always #5 clk = ~clk;

    mux_stream_arb #(.WIDTH(32), .N(4), .MODE(MUX_MODE_SEL)) u_sel (
        .clk(clk), .reset(reset), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_chan(oc[0]),
        .out_ready(out_ready));
    mux_stream_arb #(.WIDTH(32), .N(4), .MODE(MUX_MODE_RR)) u_rr (
        .clk(clk), .reset(reset), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_chan(oc[1]),
        .out_ready(out_ready));
    mux_stream_arb #(.WIDTH(32), .N(4), .MODE(MUX_MODE_PRIO)) u_prio (
        .clk(clk), .reset(reset), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[2]), .out_valid(ov[2]), .out_data(od[2]), .out_chan(oc[2]),
        .out_ready(out_ready));

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic        mv    [3];
    logic [31:0] mdata [3];
    logic [1:0]  mchan [3];
    int          mptr  [3];

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic [1:0]  chan;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  v;
        logic [31:0] d2;
        logic [3:0]  rdy_sel;
        logic [3:0]  rdy_prio;
        logic        ov_sel;
        logic [31:0] data_sel;
        logic        ov_prio;
        logic [1:0]  chan_prio;
    } vec_t;
    vec_t vt [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    function automatic void model_grant(input int mode, input int ptr, input logic [3:0] v,
                                        input logic [1:0] s, output int g, output bit gv);
        int c;
        g  = 0;
        gv = 1'b0;
        if (mode == 0) begin
            g  = int'(s);
            gv = v[s];
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = (mode == 1) ? (ptr + k) % 4 : k;
                if (!gv && v[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    // Reference model and scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        int   g;
        bit   gv;
        logic space;
        logic [3:0] exp_rdy;
        int   idx;
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                model_grant(d, mptr[d], in_valid, sel, g, gv);
                space   = !mv[d] || out_ready;
                exp_rdy = (reset && space && gv) ? (4'b0001 << g) : 4'b0000;
                check($sformatf("d%0d in_ready", d), 64'(rdy[d]), 64'(exp_rdy));
                check($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(mv[d]));
                check($sformatf("d%0d out_data", d), 64'(od[d]), 64'(mdata[d]));
                check($sformatf("d%0d out_chan", d), 64'(oc[d]), 64'(mchan[d]));
                if (reset && ov[d] && out_ready) begin
                    idx = -1;
                    foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
                    check($sformatf("d%0d sb_has_word", d), 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        check($sformatf("d%0d sb_data", d), 64'(od[d]), 64'(sb[idx].data));
                        check($sformatf("d%0d sb_chan", d), 64'(oc[d]), 64'(sb[idx].chan));
                        sb.delete(idx);
                    end
                end
                if (!reset) begin
                    mv[d] = 1'b0; mdata[d] = 32'd0; mchan[d] = 2'd0; mptr[d] = 0;
                end else if (space && gv) begin
                    mv[d]    = 1'b1;
                    mdata[d] = in_data[g*32 +: 32];
                    mchan[d] = 2'(g);
                    sb.push_back('{dut: d, data: in_data[g*32 +: 32], chan: 2'(g)});
                    if (d == 1) mptr[d] = (g == 3) ? 0 : g + 1;
                end else if (out_ready) begin
                    mv[d] = 1'b0;
                end
            end
            if (!reset) sb.delete();
        end
    end

    initial begin
        logic [1:0] rr_exp [6];
        for (int d = 0; d < 3; d++) begin
            mv[d] = 1'b0; mdata[d] = 32'd0; mchan[d] = 2'd0; mptr[d] = 0;
        end
        vt[0] = '{2'd2, 4'b0100, 32'hDEAD_BEEF, 4'b0100, 4'b0100, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2};
        vt[1] = '{2'd2, 4'b0001, 32'h3333_0002, 4'b0000, 4'b0001, 1'b0, 32'hDEAD_BEEF, 1'b1, 2'd0};
        vt[2] = '{2'd1, 4'b1010, 32'h3333_0002, 4'b0010, 4'b0010, 1'b1, 32'h2222_0001, 1'b1, 2'd1};
        vt[3] = '{2'd3, 4'b1010, 32'h3333_0002, 4'b1000, 4'b0010, 1'b1, 32'h4444_0003, 1'b1, 2'd1};
        vt[4] = '{2'd0, 4'b0000, 32'h3333_0002, 4'b0000, 4'b0000, 1'b0, 32'h4444_0003, 1'b0, 2'd1};
        vt[5] = '{2'd3, 4'b1111, 32'h3333_0002, 4'b1000, 4'b0001, 1'b1, 32'h4444_0003, 1'b1, 2'd0};
        vt[6] = '{2'd1, 4'b1100, 32'h3333_0002, 4'b0000, 4'b0100, 1'b0, 32'h4444_0003, 1'b1, 2'd2};
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003);
        tick();
        mon_en = 1'b1;

        // Held reset with all channels requesting.
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                check($sformatf("rst d%0d out_valid", d), 64'(ov[d]), 64'd0);
                check($sformatf("rst d%0d out_data", d), 64'(od[d]), 64'd0);
                check($sformatf("rst d%0d in_ready", d), 64'(rdy[d]), 64'd0);
            end
        end
        reset = 1'b1; in_valid = 4'b0000;
        tick();

        // Vector table, consumer always ready.
        for (int k = 0; k < 7; k++) begin
            sel = vt[k].sel; in_valid = vt[k].v;
            set_data(32'h1111_0000, 32'h2222_0001, vt[k].d2, 32'h4444_0003);
            #1;
            check($sformatf("vec%0d sel in_ready", k), 64'(rdy[0]), 64'(vt[k].rdy_sel));
            check($sformatf("vec%0d prio in_ready", k), 64'(rdy[2]), 64'(vt[k].rdy_prio));
            tick();
            check($sformatf("vec%0d sel out_valid", k), 64'(ov[0]), 64'(vt[k].ov_sel));
            check($sformatf("vec%0d sel out_data", k), 64'(od[0]), 64'(vt[k].data_sel));
            check($sformatf("vec%0d prio out_valid", k), 64'(ov[2]), 64'(vt[k].ov_prio));
            check($sformatf("vec%0d prio out_chan", k), 64'(oc[2]), 64'(vt[k].chan_prio));
        end

        // Round-robin rotation and wrap from a fresh pointer.
        in_valid = 4'b0000; reset = 1'b0; tick();
        reset = 1'b1; in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr seq%0d out_chan", k), 64'(oc[1]), 64'(rr_exp[k]));
            check($sformatf("rr seq%0d out_valid", k), 64'(ov[1]), 64'd1);
        end

        // Fixed priority: ch1 always beats ch3.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("prio%0d in_ready", k), 64'(rdy[2]), 64'b0010);
            tick();
            check($sformatf("prio%0d out_chan", k), 64'(oc[2]), 64'd1);
        end

        // Backpressure then back-to-back refill on the select instance.
        sel = 2'd2; in_valid = 4'b0100;
        set_data(32'h1111_0000, 32'h2222_0001, 32'h0000_00AA, 32'h4444_0003);
        tick();
        check("bp first out_data", 64'(od[0]), 64'h0000_00AA);
        out_ready = 1'b0;
        set_data(32'h1111_0000, 32'h2222_0001, 32'h0000_00BB, 32'h4444_0003);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d in_ready", k), 64'(rdy[0]), 64'd0);
            tick();
            check($sformatf("bp%0d out_data", k), 64'(od[0]), 64'h0000_00AA);
            check($sformatf("bp%0d out_valid", k), 64'(ov[0]), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(rdy[0]), 64'b0100);
        tick();
        check("bp b2b out_data", 64'(od[0]), 64'h0000_00BB);
        check("bp b2b out_valid", 64'(ov[0]), 64'd1);
        set_data(32'h1111_0000, 32'h2222_0001, 32'h0000_00CC, 32'h4444_0003);
        tick();
        check("bp b2b2 out_data", 64'(od[0]), 64'h0000_00CC);
        in_valid = 4'b0000;
        tick();
        check("bp drain out_valid", 64'(ov[0]), 64'd0);
        check("bp drain out_data", 64'(od[0]), 64'h0000_00CC);

        // Reset mid-stream on round-robin after two grants.
        reset = 1'b0; tick();
        reset = 1'b1; in_valid = 4'b1111;
        tick(); tick();
        check("mid rr second chan", 64'(oc[1]), 64'd1);
        reset = 1'b0;
        tick();
        check("mid rst out_valid", 64'(ov[1]), 64'd0);
        reset = 1'b1;
        tick();
        check("mid after out_chan", 64'(oc[1]), 64'd0);
        check("mid after out_valid", 64'(ov[1]), 64'd1);

        in_valid = 4'b0000;
        tick(); tick();
        check("sb drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
